// File: rtl/registered_sync_pkg.sv
// Shared constants and parameter checks for the registered_sync synchronizer.
package registered_sync_pkg;

    localparam int STAGES_MIN = 2;
    localparam int STAGES_MAX = 8;

    function automatic bit stages_legal(input int stages);
        return (stages >= STAGES_MIN) && (stages <= STAGES_MAX);
    endfunction

endpackage

// File: rtl/registered_sync_chain.sv
// Single-bit STAGES-deep synchronizer chain with asynchronous reset.
module sync_bit_chain #(
    parameter int   STAGES    = 2,
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic data_in,
    output logic data_out
);

    // Kept adjacent and un-retimed so metastability has a full period to settle.
    (* ASYNC_REG = "TRUE", dont_touch = "true" *)
    logic [STAGES-1:0] stage;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage <= {STAGES{RESET_BIT}};
        end else begin
            stage <= {stage[STAGES-2:0], data_in};
        end
    end

    assign data_out = stage[STAGES-1];

endmodule

// File: rtl/registered_sync.sv
// Multi-bit level synchronizer with registered-quality edge-detect pulses.
module registered_sync
    import registered_sync_pkg::*;
#(
    parameter int               STAGES      = 2,
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] data_out_rise,
    output logic [WIDTH-1:0] data_out_fall
);

    if (!stages_legal(STAGES)) begin : g_bad_stages
        $error("registered_sync: STAGES must be within 2..8");
    end

    logic [WIDTH-1:0] last;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sync_bit_chain #(
            .STAGES   (STAGES),
            .RESET_BIT(RESET_VALUE[i])
        ) u_chain (
            .clock   (clock),
            .reset   (reset),
            .data_in (data_in[i]),
            .data_out(data_out[i])
        );
    end

    // Resetting last to the same value as the chain keeps reset pulse-free.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last <= RESET_VALUE;
        end else begin
            last <= data_out;
        end
    end

    assign data_out_rise = data_out & ~last;
    assign data_out_fall = ~data_out & last;

endmodule

// File: tb/tb_registered_sync.sv
// Directed and scoreboard bench for registered_sync across several configurations.
module tb_registered_sync;

    logic       clock;
    logic       reset;
    logic       din_a;
    logic [3:0] din_g;

    logic dout0, rise0, fall0;
    logic dout1, rise1, fall1;
    logic [3:0] dout3, rise3, fall3;
    logic [3:0] dout4, rise4, fall4;

    int checks;
    int errors;

    int  glitch_bad;
    int  trans_cnt;
    bit  watch;
    longint last_t;

    registered_sync #(.STAGES(2), .WIDTH(1), .RESET_VALUE(1'b0)) dut0 (
        .clock(clock), .reset(reset), .data_in(din_a),
        .data_out(dout0), .data_out_rise(rise0), .data_out_fall(fall0)
    );

    registered_sync #(.STAGES(2), .WIDTH(1), .RESET_VALUE(1'b1)) dut1 (
        .clock(clock), .reset(reset), .data_in(din_a),
        .data_out(dout1), .data_out_rise(rise1), .data_out_fall(fall1)
    );

    registered_sync #(.STAGES(3), .WIDTH(4), .RESET_VALUE(4'h0)) dut3 (
        .clock(clock), .reset(reset), .data_in(din_g),
        .data_out(dout3), .data_out_rise(rise3), .data_out_fall(fall3)
    );

    registered_sync #(.STAGES(4), .WIDTH(4), .RESET_VALUE(4'h0)) dut4 (
        .clock(clock), .reset(reset), .data_in(din_g),
        .data_out(dout4), .data_out_rise(rise4), .data_out_fall(fall4)
    );

    initial clock = 1'b0;
    always #500 clock = ~clock;

    // Every output transition should land a whole number of periods after the last.
    always @(dout0) begin
        if (watch) begin
            if ((($time - last_t) % 1000) != 0) glitch_bad++;
            last_t = $time;
            trans_cnt++;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset = 1'b1;
        din_a = 1'b0;
        din_g = 4'h0;
        #300;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            din_a = ~din_a;
            din_g = din_g + 4'd5;
            #1;
            checks++;
            if (dout0 !== 1'b0 || dout1 !== 1'b1 || dout3 !== 4'h0 || dout4 !== 4'h0) begin
                errors++;
                $display("FAIL reset_hold: dout0=%b dout1=%b dout3=%h dout4=%h required 0 1 0 0",
                         dout0, dout1, dout3, dout4);
            end
            checks++;
            if ({rise0, fall0, rise1, fall1} !== 4'b0 || {rise3, fall3, rise4, fall4} !== 16'h0) begin
                errors++;
                $display("FAIL reset_pulses: r0=%b f0=%b r1=%b f1=%b r3=%h f3=%h r4=%h f4=%h required all 0",
                         rise0, fall0, rise1, fall1, rise3, fall3, rise4, fall4);
            end
        end
        @(negedge clock);
        din_a = 1'b0;
        din_g = 4'h0;
        reset = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (dout1 !== 1'b1 || fall1 !== 1'b0 || rise0 !== 1'b0 || fall0 !== 1'b0) begin
            errors++;
            $display("FAIL release_edge1: dout1=%b fall1=%b r0=%b f0=%b required 1 0 0 0",
                     dout1, fall1, rise0, fall0);
        end
        @(posedge clock); #1;
        checks++;
        if (dout1 !== 1'b0 || fall1 !== 1'b1 || rise1 !== 1'b0) begin
            errors++;
            $display("FAIL release_edge2: dout1=%b fall1=%b rise1=%b required 0 1 0",
                     dout1, fall1, rise1);
        end
        @(posedge clock); #1;
        checks++;
        if (dout1 !== 1'b0 || fall1 !== 1'b0) begin
            errors++;
            $display("FAIL release_edge3: dout1=%b fall1=%b required 0 0", dout1, fall1);
        end
    endtask

    task automatic test_single_step();
        @(negedge clock);
        din_a = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (dout0 !== 1'b0 || rise0 !== 1'b0 || dout1 !== 1'b0) begin
            errors++;
            $display("FAIL step_edge_n: dout0=%b rise0=%b dout1=%b required 0 0 0",
                     dout0, rise0, dout1);
        end
        @(posedge clock); #1;
        checks++;
        if (dout0 !== 1'b1 || rise0 !== 1'b1 || fall0 !== 1'b0 || dout1 !== 1'b1 || rise1 !== 1'b1) begin
            errors++;
            $display("FAIL step_edge_n1: dout0=%b rise0=%b fall0=%b dout1=%b rise1=%b required 1 1 0 1 1",
                     dout0, rise0, fall0, dout1, rise1);
        end
        @(posedge clock); #1;
        checks++;
        if (dout0 !== 1'b1 || rise0 !== 1'b0 || fall0 !== 1'b0) begin
            errors++;
            $display("FAIL step_edge_n2: dout0=%b rise0=%b fall0=%b required 1 0 0",
                     dout0, rise0, fall0);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clock);
        #100;
        reset = 1'b1;
        #1;
        checks++;
        if (dout0 !== 1'b0 || fall0 !== 1'b0 || rise0 !== 1'b0 || dout1 !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_async: dout0=%b fall0=%b rise0=%b dout1=%b required 0 0 0 1",
                     dout0, fall0, rise0, dout1);
        end
        @(posedge clock); #1;
        checks++;
        if (dout0 !== 1'b0 || fall0 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_hold: dout0=%b fall0=%b required 0 0", dout0, fall0);
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (dout0 !== 1'b0 || rise0 !== 1'b0 || fall0 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_rel1: dout0=%b rise0=%b fall0=%b required 0 0 0",
                     dout0, rise0, fall0);
        end
        @(posedge clock); #1;
        checks++;
        if (dout0 !== 1'b1 || rise0 !== 1'b1 || dout1 !== 1'b1 || fall1 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_rel2: dout0=%b rise0=%b dout1=%b fall1=%b required 1 1 1 0",
                     dout0, rise0, dout1, fall1);
        end
    endtask

    task automatic test_random();
        bit done;
        logic s_prev;
        logic exp_now;
        logic exp_prev;
        int rise_cnt;
        int fall_cnt;
        int shown;
        done = 1'b0;
        rise_cnt = 0;
        fall_cnt = 0;
        shown = 0;
        @(posedge clock);
        s_prev = din_a;
        exp_prev = 1'b1;
        #1;
        glitch_bad = 0;
        trans_cnt = 0;
        last_t = 500;
        watch = 1'b1;
        fork
            begin
                #1234;
                while (!done) begin
                    #(3142 * $urandom_range(1, 8));
                    while ((($time % 1000) > 400) && (($time % 1000) < 600)) #150;
                    din_a = ~din_a;
                end
            end
            begin
                for (int i = 0; i < 1000; i++) begin
                    @(posedge clock);
                    exp_now = s_prev;
                    s_prev = din_a;
                    #1;
                    checks++;
                    if (dout0 !== exp_now || dout1 !== exp_now ||
                        rise0 !== (exp_now & ~exp_prev) || fall0 !== (~exp_now & exp_prev)) begin
                        errors++;
                        if (shown < 10) begin
                            shown++;
                            $display("FAIL random_edge%0d: dout0=%b dout1=%b rise0=%b fall0=%b required %b %b %b %b",
                                     i, dout0, dout1, rise0, fall0, exp_now, exp_now,
                                     exp_now & ~exp_prev, ~exp_now & exp_prev);
                        end
                    end
                    if (rise0 === 1'b1) rise_cnt++;
                    if (fall0 === 1'b1) fall_cnt++;
                    exp_prev = exp_now;
                end
                watch = 1'b0;
                done = 1'b1;
            end
        join
        checks++;
        if (glitch_bad !== 0) begin
            errors++;
            $display("FAIL glitch_width: %0d non-integer pulse widths, required 0", glitch_bad);
        end
        checks++;
        if ((rise_cnt + fall_cnt) !== trans_cnt || trans_cnt < 20) begin
            errors++;
            $display("FAIL edge_count: rise=%0d fall=%0d transitions=%0d required rise+fall==transitions>=20",
                     rise_cnt, fall_cnt, trans_cnt);
        end
    endtask

    task automatic test_gray();
        logic [3:0] h[$];
        logic [3:0] cnt;
        logic [3:0] p3;
        logic [3:0] p4;
        logic [3:0] e3;
        logic [3:0] e4;
        int n;
        h = {4'h0, 4'h0, 4'h0, 4'h0};
        cnt = 4'h0;
        p3 = 4'h0;
        p4 = 4'h0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            cnt = cnt + 4'd1;
            din_g = cnt ^ (cnt >> 1);
            @(posedge clock);
            h.push_back(din_g);
            #1;
            n = h.size();
            e3 = h[n-3];
            e4 = h[n-4];
            checks++;
            if (dout3 !== e3 || dout4 !== e4) begin
                errors++;
                $display("FAIL gray_latency%0d: dout3=%h dout4=%h required %h %h",
                         i, dout3, dout4, e3, e4);
            end
            checks++;
            if ($countones(dout3 ^ p3) != ((i >= 2) ? 1 : 0) ||
                $countones(dout4 ^ p4) != ((i >= 3) ? 1 : 0) ||
                rise3 !== (e3 & ~p3) || fall4 !== (~e4 & p4)) begin
                errors++;
                $display("FAIL gray_step%0d: d3=%h p3=%h r3=%h d4=%h p4=%h f4=%h",
                         i, dout3, p3, rise3, dout4, p4, fall4);
            end
            p3 = e3;
            p4 = e4;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        watch = 1'b0;
        glitch_bad = 0;
        trans_cnt = 0;
        last_t = 0;
        test_reset();
        test_single_step();
        test_mid_reset();
        test_random();
        test_gray();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
